// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared definitions for the register-file write arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default data and register-index widths
//   NUM_REGS                : architectural register count (x0..x31)
//   src_e                   : requester ids (SRC_ALU = 0, SRC_MEM = 1)
//   wb_entry_t              : writeback entry {rd, data} at default widths
package regfile_arb_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // "reg" is a keyword, so the destination field is named rd.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// wb_fifo: synchronous FIFO holding queued writeback entries for one requester.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : enqueue push_data (ignored while full)
//   push_data   : entry to enqueue
//   pop         : dequeue head (ignored while empty)
//   head        : current head entry
//   full, empty : occupancy flags (registered state only)
module wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between the ALU
// and load writeback paths, each buffered by a wb_fifo.
//   clk, rst_n                      : clock, async active-low reset
//   aluValid/aluReady/aluReg/aluData: ALU writeback request handshake
//   memValid/memReady/memReg/memData: load writeback request handshake
//   writeEnable/writeReg/writeData  : registered register-file write port
//   pendingMask                     : bit r set while a write to xr is queued or on the port
//   busy                            : any FIFO non-empty or writeEnable high
// Build option: define ARB_ROUND_ROBIN_EN for round-robin on contention;
// otherwise the load path always wins.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                aluValid,
  output logic                aluReady,
  input  logic [ADDR_W-1:0]   aluReg,
  input  logic [DATA_W-1:0]   aluData,
  input  logic                memValid,
  output logic                memReady,
  input  logic [ADDR_W-1:0]   memReg,
  input  logic [DATA_W-1:0]   memData,
  output logic                writeEnable,
  output logic [ADDR_W-1:0]   writeReg,
  output logic [DATA_W-1:0]   writeData,
  output logic [NUM_REGS-1:0] pendingMask,
  output logic                busy
);

  localparam int unsigned EW    = ADDR_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(2*DEPTH+2);

  logic              alu_full, alu_empty, mem_full, mem_empty;
  logic [EW-1:0]     alu_head, mem_head;
  logic              alu_push, mem_push, alu_pop, mem_pop;
  logic              grant_mem;
  logic [CNT_W-1:0]  cnt [NUM_REGS];
  src_e              owner [NUM_REGS];

  assign aluReady = !alu_full;
  assign memReady = !mem_full;

  // x0 requests complete the handshake but are dropped here.
  assign alu_push = aluValid && aluReady && (aluReg != '0);
  assign mem_push = memValid && memReady && (memReg != '0);

  wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_push),
    .push_data ({aluReg, aluData}),
    .pop       (alu_pop),
    .head      (alu_head),
    .full      (alu_full),
    .empty     (alu_empty)
  );

  wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_mem_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (mem_push),
    .push_data ({memReg, memData}),
    .pop       (mem_pop),
    .head      (mem_head),
    .full      (mem_full),
    .empty     (mem_empty)
  );

`ifdef ARB_ROUND_ROBIN_EN
  src_e rr_ptr;

  // Pointer names the winner of the next contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= SRC_ALU;
    end else if (!alu_empty && !mem_empty) begin
      rr_ptr <= (rr_ptr == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end
  end

  assign grant_mem = !mem_empty && (alu_empty || (rr_ptr == SRC_MEM));
`else
  assign grant_mem = !mem_empty;
`endif

  assign mem_pop = grant_mem;
  assign alu_pop = !alu_empty && !grant_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeEnable <= 1'b0;
      writeReg    <= '0;
      writeData   <= '0;
    end else if (alu_pop || mem_pop) begin
      writeEnable            <= 1'b1;
      {writeReg, writeData}  <= grant_mem ? mem_head : alu_head;
    end else begin
      writeEnable <= 1'b0;
    end
  end

  // Per-register occupancy: +1 on enqueue, -1 at the edge where the port
  // entry is written into the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        cnt[r] <= cnt[r]
                + CNT_W'(alu_push && (aluReg == ADDR_W'(r)))
                + CNT_W'(mem_push && (memReg == ADDR_W'(r)))
                - CNT_W'(writeEnable && (writeReg == ADDR_W'(r)));
      end
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) pendingMask[r] = (cnt[r] != '0);
  end

  assign busy = !alu_empty || !mem_empty || writeEnable;

  // Last enqueuing source per register; only consulted by the checks below.
  always_ff @(posedge clk) begin
    if (alu_push) owner[aluReg] <= SRC_ALU;
    if (mem_push) owner[memReg] <= SRC_MEM;
  end

  a_no_cross_alu: assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_push && pendingMask[aluReg] && (owner[aluReg] != SRC_ALU)));
  a_no_cross_mem: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_push && pendingMask[memReg] && (owner[memReg] != SRC_MEM)));
  a_no_same_reg:  assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_push && mem_push && (aluReg == memReg)));

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(writeEnable && (writeReg == ADDR_W'(r)) && (cnt[r] == '0)));
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
      !(((alu_push && (aluReg == ADDR_W'(r))) || (mem_push && (memReg == ADDR_W'(r))))
        && !(writeEnable && (writeReg == ADDR_W'(r))) && (cnt[r] == '1)));
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table,
// contention/backpressure and reset sequences, then randomized traffic
// against a queue-based reference model. Honours ARB_ROUND_ROBIN_EN.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aluValid, aluReady, memValid, memReady;
  logic [4:0]  aluReg, memReg, writeReg;
  logic [31:0] aluData, memData, writeData, pendingMask;
  logic        writeEnable, busy;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluValid(aluValid), .aluReady(aluReady), .aluReg(aluReg), .aluData(aluData),
    .memValid(memValid), .memReady(memReady), .memReg(memReg), .memData(memData),
    .writeEnable(writeEnable), .writeReg(writeReg), .writeData(writeData),
    .pendingMask(pendingMask), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: per-source queues, one port slot, optional RR pointer.
  wb_entry_t aq[$];
  wb_entry_t mq[$];
  wb_entry_t port_e;
  bit        port_we;
  int        port_src;
  int        rr_mem;

  task automatic model_reset();
    aq.delete(); mq.delete();
    port_e = '0; port_we = 0; port_src = 0; rr_mem = 0;
  endtask

  function automatic bit pend_by(input int src, input logic [4:0] r);
    if (port_we && port_src == src && port_e.rd == r) return 1;
    if (src == 0) begin
      foreach (aq[i]) if (aq[i].rd == r) return 1;
    end else begin
      foreach (mq[i]) if (mq[i].rd == r) return 1;
    end
    return 0;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (aq[i]) m[aq[i].rd] = 1'b1;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    if (port_we) m[port_e.rd] = 1'b1;
    return m;
  endfunction

  task automatic model_edge(input bit a_acc, input bit m_acc, input wb_entry_t ae, input wb_entry_t me);
    bit a_ne, m_ne, take_mem;
    a_ne = aq.size() > 0;
    m_ne = mq.size() > 0;
    take_mem = m_ne;
    if (a_ne && m_ne) begin
`ifdef ARB_ROUND_ROBIN_EN
      take_mem = (rr_mem != 0);
      rr_mem   = 1 - rr_mem;
`else
      take_mem = 1;
`endif
    end
    if (a_ne || m_ne) begin
      port_e   = take_mem ? mq.pop_front() : aq.pop_front();
      port_src = take_mem ? 1 : 0;
      port_we  = 1;
    end else begin
      port_we = 0;
    end
    if (a_acc && ae.rd != 0) aq.push_back(ae);
    if (m_acc && me.rd != 0) mq.push_back(me);
  endtask

  typedef struct packed {
    logic        av; logic [4:0] ar; logic [31:0] ad;
    logic        mv; logic [4:0] mr; logic [31:0] md;
    logic        we; logic [4:0] wr; logic [31:0] wd;
    logic [31:0] pm; logic       bz;
  } vec_t;

  vec_t      vecs[12];
  wb_entry_t got[$];
  int        exp_order[6];

  initial begin
    int ai, mi;
    bit saw_full;

    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        32'h20,  1'b1};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hDEADBEEF, 32'h20,  1'b1};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hDEADBEEF, 32'h0,   1'b0};
    vecs[3]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hDEADBEEF, 32'h0,   1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hDEADBEEF, 32'h0,   1'b0};
    vecs[5]  = '{1'b1, 5'd7, 32'h11,       1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hDEADBEEF, 32'h80,  1'b1};
    vecs[6]  = '{1'b1, 5'd7, 32'h22,       1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h11,       32'h80,  1'b1};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h22,       32'h80,  1'b1};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd7, 32'h22,       32'h0,   1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hCAFE, 1'b0, 5'd7, 32'h22,       32'h200, 1'b1};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'hCAFE,     32'h200, 1'b1};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd9, 32'hCAFE,     32'h0,   1'b0};

`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 4, 2, 5, 3, 6};
`else
    exp_order = '{4, 5, 6, 1, 2, 3};
`endif

    rst_n = 1'b0;
    aluValid = 0; aluReg = '0; aluData = '0;
    memValid = 0; memReg = '0; memData = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset_we", writeEnable, 1'b0);
    check("reset_wreg", writeReg, 5'd0);
    check("reset_wdata", writeData, 32'd0);
    check("reset_pm", pendingMask, 32'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_aluReady", aluReady, 1'b1);
    check("reset_memReady", memReady, 1'b1);

    // Directed vectors: single write, x0 filter, same-reg pair, load write.
    for (int i = 0; i < 12; i++) begin
      aluValid = vecs[i].av; aluReg = vecs[i].ar; aluData = vecs[i].ad;
      memValid = vecs[i].mv; memReg = vecs[i].mr; memData = vecs[i].md;
      check($sformatf("tbl%0d_aluReady", i), aluReady, 1'b1);
      check($sformatf("tbl%0d_memReady", i), memReady, 1'b1);
      tick();
      check($sformatf("tbl%0d_we", i), writeEnable, vecs[i].we);
      check($sformatf("tbl%0d_wreg", i), writeReg, vecs[i].wr);
      check($sformatf("tbl%0d_wdata", i), writeData, vecs[i].wd);
      check($sformatf("tbl%0d_pm", i), pendingMask, vecs[i].pm);
      check($sformatf("tbl%0d_busy", i), busy, vecs[i].bz);
    end
    aluValid = 0; memValid = 0;

    // Contention with backpressure: three requests per source, held until accepted.
    ai = 0; mi = 0; saw_full = 0; got.delete();
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      bit a_acc, m_acc;
      aluValid = (ai < 3); aluReg = 5'(ai + 1); aluData = 32'(256 + ai + 1);
      memValid = (mi < 3); memReg = 5'(mi + 4); memData = 32'(256 + mi + 4);
      if (!aluReady || !memReady) saw_full = 1;
      a_acc = aluValid && aluReady;
      m_acc = memValid && memReady;
      tick();
      if (a_acc) ai++;
      if (m_acc) mi++;
      if (writeEnable) got.push_back('{writeReg, writeData});
    end
    aluValid = 0; memValid = 0;
    check("cont_count", 64'(got.size()), 64'd6);
    check("cont_backpressure", saw_full, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("cont_reg%0d", i), (i < got.size()) ? 64'(got[i].rd) : 64'hFF, 64'(exp_order[i]));
      check($sformatf("cont_data%0d", i), (i < got.size()) ? 64'(got[i].data) : 64'hFF, 64'(256 + exp_order[i]));
    end
    tick(); tick();
    check("cont_drained_busy", busy, 1'b0);

    // Asynchronous reset with writes queued and one on the port.
    aluValid = 1; aluReg = 5'd3;  aluData = 32'h33;
    memValid = 1; memReg = 5'd12; memData = 32'hC;
    tick();
    aluReg = 5'd10; aluData = 32'hA; memReg = 5'd11; memData = 32'hB;
    tick();
    aluValid = 0; memValid = 0;
    check("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_we", writeEnable, 1'b0);
    check("async_rst_wreg", writeReg, 5'd0);
    check("async_rst_wdata", writeData, 32'd0);
    check("async_rst_pm", pendingMask, 32'd0);
    check("async_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_aluReady", aluReady, 1'b1);
    check("post_rst_memReady", memReady, 1'b1);
    tick();
    check("post_rst_we", writeEnable, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_pm", pendingMask, 32'd0);

    // Randomized traffic against the reference model.
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic [4:0] ar, mr;
      bit a_acc, m_acc;
      wb_entry_t ae, me;
      ar = 5'($urandom_range(0, 7));
      mr = 5'($urandom_range(0, 7));
      aluValid = ($urandom_range(0, 3) != 0) && !pend_by(1, ar);
      memValid = ($urandom_range(0, 3) != 0) && !pend_by(0, mr);
      if (aluValid && memValid && ar == mr && ar != 0) memValid = 0;
      aluReg = ar; aluData = $urandom;
      memReg = mr; memData = $urandom;
      check("rand_aluReady", aluReady, aq.size() < DEPTH);
      check("rand_memReady", memReady, mq.size() < DEPTH);
      a_acc = aluValid && (aq.size() < DEPTH);
      m_acc = memValid && (mq.size() < DEPTH);
      ae = '{aluReg, aluData};
      me = '{memReg, memData};
      tick();
      model_edge(a_acc, m_acc, ae, me);
      check("rand_we", writeEnable, port_we);
      check("rand_wreg", writeReg, port_e.rd);
      check("rand_wdata", writeData, port_e.data);
      check("rand_pm", pendingMask, model_mask());
      check("rand_busy", busy, (aq.size() > 0) || (mq.size() > 0) || port_we);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
